countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//  Settable countdown timer feeding mode input 3 of the display mux with a packed 27-bit time word.
//  Runs on the 1 kHz divided clock. Takes the raw toggle/add_one/add_ten buttons and the unit-select switches.
//  Debounces the buttons internally, edits the selected field, and counts down to zero at 1/100 s resolution.
// PARAMETERS
//  DB_CYCLES     10  consecutive stable cycles before a button change is accepted
//  TICKS_PER_CS  10  clk cycles per 1/100 s decrement
// PORTS
//  clk       in   1   1 kHz clock, sole clock domain
//  reset     in   1   synchronous, active-low reset
//  toggle    in   1   raw button: start / pause / resume / acknowledge
//  add_one   in   1   raw button: add 1 to selected field
//  add_ten   in   1   raw button: add 10 to selected field
//  ms_sw     in   1   select hundredths field
//  s_sw      in   1   select seconds field
//  min_sw    in   1   select minutes field
//  hr_sw     in   1   select hours field
//  out_time  out  27  {hr[26:22], min[21:16], sec[15:10], cs[9:3], 3'b000}
//  running   out  1   high in RUN
//  done      out  1   high in DONE
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - out_time=0, running=0, done=0, state=IDLE.
//   - Prescaler, synchronisers and debouncers are cleared.
//  Button path, per button:
//   - 2-FF synchroniser, then debounce counter, then rising-edge detect.
//   - The event is a 1-cycle pulse, issued DB_CYCLES+2 cycles after the first posedge that samples the input high.
//   - Any high or low glitch shorter than DB_CYCLES cycles is ignored.
//   - A release never generates an event.
//  Field select:
//   - Priority hr_sw > min_sw > s_sw > ms_sw.
//   - No switch set: add events are ignored.
//  Edit (IDLE and PAUSED only; ignored in RUN and DONE):
//   - Applied on the cycle after the event pulse.
//   - Field takes (field+N) mod limit, where N=1 or 10 and limit is cs 100, sec 60, min 60, hr 24.
//   - No carry into the neighbouring field.
//   - add_one and add_ten events in the same cycle: add_ten wins.
//  States:
//   - IDLE: toggle with out_time!=0 -> RUN, prescaler cleared. Toggle with out_time==0 -> stays IDLE.
//   - RUN: the prescaler counts 0..TICKS_PER_CS-1. On wrap, the word decrements by 1 cs.
//     - Borrow chain: cs 0->99 borrows from sec; sec 0->59 borrows from min; min 0->59 borrows from hr.
//     - When the decrement produces all-zero, go to DONE on the same edge; out_time=0.
//     - toggle -> PAUSED.
//   - PAUSED: word and prescaler frozen; toggle -> RUN.
//     - If the edits leave the word zero, toggle -> IDLE instead.
//   - DONE: out_time held at 0, done=1. toggle -> IDLE.
//  Simultaneous events:
//   - toggle in the same cycle as an add event: toggle is acted on, the add is dropped.
//   - toggle in the same cycle as the final decrement: DONE wins.
//  Outputs are registered; out_time bits [2:0] are always 0.
// TESTING  (bench: DB_CYCLES=2, TICKS_PER_CS=1)
//  1. Hold reset=0 for 3 cycles, then release -> out_time=0, running=0, done=0.
//  2. s_sw=1; add_ten x2; add_one x3 -> out_time=23<<10.
//     Then add_ten x4 -> sec=(23+40) mod 60 = 3; min field unchanged.
//  3. Set sec=1 (out_time=1<<10); press toggle.
//     -> running=1; after 1 tick cs=99, sec=0; after 100 ticks out_time=0, done=1, running=0.
//     Then toggle -> IDLE, done=0.
//  4. Set min=1; start; pause after 150 ticks -> out_time=(58<<10)|(50<<3), frozen for 50 cycles.
//     add_one on cs -> cs=51; toggle -> resumes from 0:00:58.51.
//  5. toggle in IDLE with out_time=0 -> running stays 0.
//     Reset asserted mid-RUN -> all outputs 0 on the next edge.
//  6. add_one pulse 1 cycle wide (< DB_CYCLES) -> no change.
//     add_one and add_ten debounced together with hr_sw=1 -> hr=10.

Source files
------------

// File: rtl/countdown_timer.sv
// Settable countdown timer: debounced buttons edit an hr:min:sec:cs word,
// which then counts down to zero at 1/100 s resolution.
module countdown_timer #(
    parameter int DB_CYCLES    = 10,
    parameter int TICKS_PER_CS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        toggle,
    input  logic        add_one,
    input  logic        add_ten,
    input  logic        ms_sw,
    input  logic        s_sw,
    input  logic        min_sw,
    input  logic        hr_sw,
    output logic [26:0] out_time,
    output logic        running,
    output logic        done
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int PW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_CS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    // ---------------- button conditioning: bit 0 toggle, 1 add_one, 2 add_ten
    logic [2:0]    btn_raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    stable_q, stable_d;
    logic [2:0]    prev_q;
    logic [2:0]    evt_q, evt_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    assign btn_raw = {add_ten, add_one, toggle};

    // The counter only runs while the synchronised input disagrees with the
    // accepted level, so any shorter excursion restarts it from zero.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_LAST) stable_d[i] = sync2_q[i];
                else                     cnt_d[i]    = cnt_q[i] + 1'b1;
            end
        end
        evt_d = stable_q & ~prev_q;
    end

    // ---------------- time word and control
    state_t        state_q, state_d;
    logic [4:0]    hr_q, hr_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [6:0]    cs_q, cs_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          done_q, done_d;

    logic          ev_tog, ev_add, word_zero, tick;
    logic [3:0]    step;
    logic [5:0]    hr_sum;
    logic [6:0]    min_sum, sec_sum;
    logic [7:0]    cs_sum;
    logic [4:0]    hr_edit;
    logic [5:0]    min_edit, sec_edit;
    logic [6:0]    cs_edit;
    logic [4:0]    dec_hr;
    logic [5:0]    dec_min, dec_sec;
    logic [6:0]    dec_cs;
    logic          borrow_s, borrow_m, borrow_h, dec_zero;

    assign ev_tog    = evt_q[0];
    assign ev_add    = evt_q[1] | evt_q[2];
    assign step      = evt_q[2] ? 4'd10 : 4'd1;
    assign word_zero = (hr_q == '0) && (min_q == '0) && (sec_q == '0) && (cs_q == '0);
    assign tick      = (presc_q == TICK_LAST);

    // Fields are always below their limit, so one conditional subtract is a full modulo.
    assign hr_sum   = {1'b0, hr_q}  + {2'b00, step};
    assign min_sum  = {1'b0, min_q} + {3'b000, step};
    assign sec_sum  = {1'b0, sec_q} + {3'b000, step};
    assign cs_sum   = {1'b0, cs_q}  + {4'b0000, step};
    assign hr_edit  = (hr_sum  >= 6'd24)  ? 5'(hr_sum  - 6'd24)  : hr_sum[4:0];
    assign min_edit = (min_sum >= 7'd60)  ? 6'(min_sum - 7'd60)  : min_sum[5:0];
    assign sec_edit = (sec_sum >= 7'd60)  ? 6'(sec_sum - 7'd60)  : sec_sum[5:0];
    assign cs_edit  = (cs_sum  >= 8'd100) ? 7'(cs_sum  - 8'd100) : cs_sum[6:0];

    assign borrow_s = (cs_q == '0);
    assign borrow_m = borrow_s && (sec_q == '0);
    assign borrow_h = borrow_m && (min_q == '0);
    assign dec_cs   = borrow_s ? 7'd99 : cs_q - 7'd1;
    assign dec_sec  = borrow_s ? ((sec_q == '0) ? 6'd59 : sec_q - 6'd1) : sec_q;
    assign dec_min  = borrow_m ? ((min_q == '0) ? 6'd59 : min_q - 6'd1) : min_q;
    assign dec_hr   = borrow_h ? hr_q - 5'd1 : hr_q;
    assign dec_zero = (dec_hr == '0) && (dec_min == '0) && (dec_sec == '0) && (dec_cs == '0);

    always_comb begin
        state_d = state_q;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        cs_d    = cs_q;
        presc_d = presc_q;
        case (state_q)
            IDLE, PAUSED: begin
                if (ev_tog) begin
                    if (word_zero) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                        if (state_q == IDLE) presc_d = '0;
                    end
                end else if (ev_add) begin
                    if      (hr_sw)  hr_d  = hr_edit;
                    else if (min_sw) min_d = min_edit;
                    else if (s_sw)   sec_d = sec_edit;
                    else if (ms_sw)  cs_d  = cs_edit;
                end
            end
            RUN: begin
                // Reaching zero outranks a pause requested on the same edge.
                if (tick && dec_zero) begin
                    state_d = DONE;
                    hr_d    = '0;
                    min_d   = '0;
                    sec_d   = '0;
                    cs_d    = '0;
                end else if (ev_tog) begin
                    state_d = PAUSED;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        hr_d  = dec_hr;
                        min_d = dec_min;
                        sec_d = dec_sec;
                        cs_d  = dec_cs;
                    end
                end
            end
            default: begin
                hr_d  = '0;
                min_d = '0;
                sec_d = '0;
                cs_d  = '0;
                if (ev_tog) state_d = IDLE;
            end
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            prev_q    <= '0;
            evt_q     <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            state_q   <= IDLE;
            hr_q      <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            cs_q      <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            prev_q    <= stable_q;
            evt_q     <= evt_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            state_q   <= state_d;
            hr_q      <= hr_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            cs_q      <= cs_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign out_time = {hr_q, min_q, sec_q, cs_q, 3'b000};
    assign running  = running_q;
    assign done     = done_q;

endmodule
